// File: rtl/lb_read_scheduler.sv
// rtl/lb_read_scheduler.sv - round-robin locked-burst read scheduler for the line buffer read port
// Define LB_SCHED_FIXED_PRIO_EN to replace round-robin with fixed lowest-index priority.
module lb_read_scheduler #(
  parameter int N      = 4,
  parameter int ID_W   = 2,
  parameter int OFF_W  = 2,
  parameter int BEATS  = 4,
  parameter int DATA_W = 64
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [N-1:0]       io_in_valid,
  output logic [N-1:0]       io_in_ready,
  input  logic [N*ID_W-1:0]  io_in_id,
  input  logic [N*OFF_W-1:0] io_in_offset,
  output logic               io_lb_req_valid,
  input  logic               io_lb_req_ready,
  output logic [ID_W-1:0]    io_lb_req_id,
  output logic [OFF_W-1:0]   io_lb_req_offset,
  input  logic               io_lb_rsp_valid,
  input  logic [DATA_W-1:0]  io_lb_rsp_data,
  output logic [N-1:0]       io_rsp_valid,
  output logic [DATA_W-1:0]  io_rsp_data,
  output logic               io_rsp_last,
  output logic               io_busy,
  output logic               io_err
);
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int CNT_W = OFF_W + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDX_W-1:0] r_owner;
  logic [ID_W-1:0]  r_id;
  logic [OFF_W-1:0] r_off;
  logic [CNT_W-1:0] r_issue_cnt;
  logic [CNT_W-1:0] r_rsp_cnt;
  logic             r_err;
  logic [IDX_W-1:0] w_start;
  logic [IDX_W-1:0] w_gnt_idx;
  logic             w_gnt_found;
  int               w_scan;
  logic             w_accept;
  logic             w_req_fire;
  logic             w_rsp_ok;

`ifdef LB_SCHED_FIXED_PRIO_EN
  assign w_start = '0;
`else
  logic [IDX_W-1:0] r_rr;
  assign w_start = r_rr;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rr <= '0;
    end else if (w_accept) begin
      r_rr <= (int'(w_gnt_idx) == N - 1) ? '0 : w_gnt_idx + IDX_W'(1);
    end
  end
`endif

  // First valid requester at or above the scan start, wrapping modulo N.
  always_comb begin
    w_gnt_found = 1'b0;
    w_gnt_idx   = '0;
    w_scan      = 0;
    for (int k = 0; k < N; k++) begin
      w_scan = (int'(w_start) + k) % N;
      if (!w_gnt_found && io_in_valid[w_scan[IDX_W-1:0]]) begin
        w_gnt_found = 1'b1;
        w_gnt_idx   = w_scan[IDX_W-1:0];
      end
    end
  end

  assign w_accept   = (r_state == S_IDLE) && w_gnt_found;
  assign w_req_fire = (r_state == S_ISSUE) && io_lb_req_ready;
  // A beat is routable only while one is outstanding; anything else is dropped and flagged.
  assign w_rsp_ok   = io_lb_rsp_valid && (r_state != S_IDLE) && (r_rsp_cnt != r_issue_cnt);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_ISSUE;
      S_ISSUE: if (w_req_fire && (r_issue_cnt == LAST_CNT)) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_rsp_ok && (r_rsp_cnt == LAST_CNT)) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    io_in_ready     = '0;
    io_lb_req_valid = 1'b0;
    io_rsp_valid    = '0;
    io_rsp_last     = 1'b0;
    io_busy         = (r_state != S_IDLE);
    if ((r_state == S_IDLE) && w_gnt_found && reset_n) io_in_ready[w_gnt_idx] = 1'b1;
    if (r_state == S_ISSUE) io_lb_req_valid = 1'b1;
    if (w_rsp_ok) begin
      io_rsp_valid[r_owner] = 1'b1;
      io_rsp_last           = (r_rsp_cnt == LAST_CNT);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_owner     <= '0;
      r_id        <= '0;
      r_off       <= '0;
      r_issue_cnt <= '0;
      r_rsp_cnt   <= '0;
      r_err       <= 1'b0;
    end else begin
      if (w_accept) begin
        r_owner     <= w_gnt_idx;
        r_id        <= io_in_id[w_gnt_idx*ID_W +: ID_W];
        r_off       <= io_in_offset[w_gnt_idx*OFF_W +: OFF_W];
        r_issue_cnt <= '0;
        r_rsp_cnt   <= '0;
      end else begin
        if (w_req_fire) r_issue_cnt <= r_issue_cnt + CNT_W'(1);
        if (w_rsp_ok)   r_rsp_cnt   <= r_rsp_cnt + CNT_W'(1);
      end
      if (io_lb_rsp_valid && !w_rsp_ok) r_err <= 1'b1;
    end
  end

  // Critical word first: the offset add truncates so the burst wraps within the line.
  assign io_lb_req_id     = r_id;
  assign io_lb_req_offset = r_off + r_issue_cnt[OFF_W-1:0];
  assign io_rsp_data      = io_lb_rsp_data;
  assign io_err           = r_err;

endmodule

// File: tb/tb_lb_read_scheduler.sv
// tb/tb_lb_read_scheduler.sv - randomized scoreboard bench for lb_read_scheduler
module tb_lb_read_scheduler;
  localparam int N = 4, ID_W = 2, OFF_W = 2, BEATS = 4, DATA_W = 64;

  typedef struct { int id; int off; int owner; bit last; } beat_t;
  typedef struct { int due; logic [63:0] data; int owner; bit last; } pend_t;
  typedef struct { int owner; logic [63:0] data; bit last; } rsp_t;

  logic               clock = 1'b0;
  logic               reset_n;
  logic [N-1:0]       io_in_valid;
  logic [N-1:0]       io_in_ready;
  logic [N*ID_W-1:0]  io_in_id;
  logic [N*OFF_W-1:0] io_in_offset;
  logic               io_lb_req_valid;
  logic               io_lb_req_ready;
  logic [ID_W-1:0]    io_lb_req_id;
  logic [OFF_W-1:0]   io_lb_req_offset;
  logic               io_lb_rsp_valid;
  logic [DATA_W-1:0]  io_lb_rsp_data;
  logic [N-1:0]       io_rsp_valid;
  logic [DATA_W-1:0]  io_rsp_data;
  logic               io_rsp_last;
  logic               io_busy;
  logic               io_err;

  lb_read_scheduler #(.N(N), .ID_W(ID_W), .OFF_W(OFF_W), .BEATS(BEATS), .DATA_W(DATA_W)) dut (
    .clock(clock), .reset_n(reset_n),
    .io_in_valid(io_in_valid), .io_in_ready(io_in_ready), .io_in_id(io_in_id), .io_in_offset(io_in_offset),
    .io_lb_req_valid(io_lb_req_valid), .io_lb_req_ready(io_lb_req_ready),
    .io_lb_req_id(io_lb_req_id), .io_lb_req_offset(io_lb_req_offset),
    .io_lb_rsp_valid(io_lb_rsp_valid), .io_lb_rsp_data(io_lb_rsp_data),
    .io_rsp_valid(io_rsp_valid), .io_rsp_data(io_rsp_data), .io_rsp_last(io_rsp_last),
    .io_busy(io_busy), .io_err(io_err)
  );

  always #5 clock = ~clock;

  beat_t        exp_beats[$];
  pend_t        pend[$];
  rsp_t         exp_rsp[$];
  int           grant_log[$];
  int           vectors = 0, miscompares = 0, cyc = 0, m_rr = 0, lb_fires = 0;
  int           req_mode = 0, rdy_mode = 0;
  bit           m_busy = 0, m_err = 0, stray_req = 0, stray_now = 0;
  logic [N-1:0] acc_mask = '0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
  endtask

  // Monitor / reference model: arbitration, burst beat order and response routing from the rules.
  always @(negedge clock) begin : monitor
    int    w, idx;
    logic [N-1:0] exp_rdy;
    beat_t b;
    rsp_t  r;
    cyc++;
    if (!reset_n) begin
      check("rst_in_ready", io_in_ready, '0);
      check("rst_lb_req_valid", io_lb_req_valid, '0);
      check("rst_rsp_valid", io_rsp_valid, '0);
      check("rst_busy", io_busy, '0);
      check("rst_err", io_err, '0);
      m_rr = 0; m_busy = 0; m_err = 0; acc_mask = '0;
      exp_beats.delete(); pend.delete(); exp_rsp.delete();
    end else begin
      check("err", io_err, m_err);
      check("busy", io_busy, m_busy);
      w = -1;
      if (!m_busy) begin
        for (int k = 0; k < N; k++) begin
          idx = (m_rr + k) % N;
          if (w < 0 && io_in_valid[idx]) w = idx;
        end
      end
      exp_rdy = '0;
      if (w >= 0) exp_rdy[w] = 1'b1;
      check("in_ready", io_in_ready, exp_rdy);
      check("lb_req_valid", io_lb_req_valid, exp_beats.size() > 0);
      if (io_lb_req_valid && exp_beats.size() > 0) begin
        check("lb_req_id", io_lb_req_id, exp_beats[0].id);
        check("lb_req_offset", io_lb_req_offset, exp_beats[0].off);
        if (io_lb_req_ready) begin
          b = exp_beats.pop_front();
          lb_fires++;
          pend.push_back('{cyc + $urandom_range(0, 2), {$urandom, $urandom}, b.owner, b.last});
        end
      end
      if (io_lb_rsp_valid) begin
        if (stray_now) begin
          check("stray_rsp_valid", io_rsp_valid, '0);
          m_err = 1;
        end else if (exp_rsp.size() == 0) begin
          fail_now("rsp_scoreboard_empty");
        end else begin
          r = exp_rsp.pop_front();
          check("rsp_valid", io_rsp_valid, 64'(1) << r.owner);
          check("rsp_data", io_rsp_data, r.data);
          check("rsp_last", io_rsp_last, r.last);
          if (r.last) m_busy = 0;
        end
      end else begin
        check("rsp_idle_valid", io_rsp_valid, '0);
        check("rsp_idle_last", io_rsp_last, '0);
      end
      acc_mask = '0;
      if (w >= 0) begin
        acc_mask[w] = 1'b1;
        grant_log.push_back(w);
        m_busy = 1;
`ifdef LB_SCHED_FIXED_PRIO_EN
        m_rr = 0;
`else
        m_rr = (w + 1) % N;
`endif
        for (int k = 0; k < BEATS; k++)
          exp_beats.push_back('{int'(io_in_id[w*ID_W +: ID_W]),
                                (int'(io_in_offset[w*OFF_W +: OFF_W]) + k) % BEATS, w, k == BEATS - 1});
      end
    end
  end

  task automatic set_req(int i, int id, int off);
    io_in_id[i*ID_W +: ID_W]     = ID_W'(id);
    io_in_offset[i*OFF_W +: OFF_W] = OFF_W'(off);
    io_in_valid[i]               = 1'b1;
  endtask

  task automatic drive();
    pend_t p;
    for (int i = 0; i < N; i++) begin
      if (acc_mask[i]) begin
        if (req_mode == 2) set_req(i, $urandom_range(0, 3), $urandom_range(0, 3));
        else io_in_valid[i] = 1'b0;
      end else if (req_mode == 1) begin
        if (!io_in_valid[i] && $urandom_range(0, 3) == 0) set_req(i, $urandom_range(0, 3), $urandom_range(0, 3));
        else if (io_in_valid[i] && $urandom_range(0, 15) == 0) io_in_valid[i] = 1'b0;
      end
    end
    case (rdy_mode)
      0:       io_lb_req_ready = 1'b1;
      1:       io_lb_req_ready = (cyc % 3 == 0);
      default: io_lb_req_ready = 1'($urandom_range(0, 1));
    endcase
    stray_now = 0;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      p = pend.pop_front();
      io_lb_rsp_valid = 1'b1;
      io_lb_rsp_data  = p.data;
      exp_rsp.push_back('{p.owner, p.data, p.last});
    end else if (stray_req) begin
      stray_req = 0;
      stray_now = 1;
      io_lb_rsp_valid = 1'b1;
      io_lb_rsp_data  = {$urandom, $urandom};
    end else begin
      io_lb_rsp_valid = 1'b0;
      io_lb_rsp_data  = {$urandom, $urandom};
    end
  endtask

  task automatic step(int n);
    repeat (n) begin
      @(posedge clock);
      #1;
      drive();
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((m_busy || io_in_valid != 0 || exp_beats.size() > 0 || pend.size() > 0 || exp_rsp.size() > 0)
           && n < 300) begin
      step(1);
      n++;
    end
    if (n >= 300) fail_now("wait_idle");
  endtask

  task automatic wait_grants(int cnt, string name);
    int n = 0;
    while (grant_log.size() < cnt && n < 200) begin
      step(1);
      n++;
    end
    if (grant_log.size() < cnt) fail_now(name);
  endtask

  initial begin
    int exp_order[5];
`ifdef LB_SCHED_FIXED_PRIO_EN
    exp_order = '{0, 0, 0, 0, 0};
`else
    exp_order = '{0, 1, 2, 3, 0};
`endif
    reset_n = 1'b0;
    io_in_valid = '1;
    io_in_id = 8'hb4;
    io_in_offset = 8'h1e;
    io_lb_req_ready = 1'b0;
    io_lb_rsp_valid = 1'b0;
    io_lb_rsp_data = '0;
    repeat (3) @(negedge clock);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    req_mode = 2;
    rdy_mode = 0;
    grant_log.delete();

    wait_grants(5, "rr_timeout");
    if (grant_log.size() >= 5)
      for (int k = 0; k < 5; k++) check("rr_grant_order", grant_log[k], exp_order[k]);
    req_mode = 0;
    io_in_valid = '0;
    wait_idle();

    lb_fires = 0;
    set_req(0, 2, 1);
    wait_idle();
    check("single_burst_fires", lb_fires, 4);

    lb_fires = 0;
    rdy_mode = 1;
    set_req(2, 1, 3);
    wait_idle();
    check("backpressure_fires", lb_fires, 4);
    rdy_mode = 0;

    stray_req = 1;
    step(3);
    check("err_sticky", io_err, 1);
    set_req(3, 0, 2);
    wait_idle();
    check("err_still_set", io_err, 1);

    req_mode = 1;
    rdy_mode = 2;
    step(600);
    req_mode = 0;
    io_in_valid = '0;
    wait_idle();
    rdy_mode = 0;

    lb_fires = 0;
    set_req(1, 3, 2);
    begin
      int n = 0;
      while (lb_fires < 2 && n < 50) begin
        step(1);
        n++;
      end
      if (lb_fires < 2) fail_now("midburst_fires");
    end
    io_in_valid = '1;
    io_lb_rsp_valid = 1'b0;
    stray_now = 0;
    reset_n = 1'b0;
    #1;
    check("midrst_lb_req_valid", io_lb_req_valid, 0);
    check("midrst_busy", io_busy, 0);
    check("midrst_in_ready", io_in_ready, 0);
    check("midrst_rsp_valid", io_rsp_valid, 0);
    check("midrst_err", io_err, 0);
    step(2);
    reset_n = 1'b1;
    req_mode = 2;
    grant_log.delete();
    wait_grants(1, "post_reset_grant");
    if (grant_log.size() >= 1) check("post_reset_rr_start", grant_log[0], 0);
    req_mode = 0;
    io_in_valid = '0;
    wait_idle();

    stray_req = 1;
    step(3);
    check("stray_after_reset_err", io_err, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
